// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed N-digit 7-segment scan controller with blanking gaps,
// frame-synchronous value update and optional leading-zero blanking.
`default_nettype none

module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load,
    input  logic [4*NUM_DIGITS-1:0]       value_in,
    input  logic                          lz_en,
    output logic [3:0]                    hex_out,
    output logic [NUM_DIGITS-1:0]         an_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_tick,
    output logic                          load_ack
);

    localparam int IW     = $clog2(NUM_DIGITS);
    localparam int MAXLEN = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW     = $clog2(MAXLEN + 1);

    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [3:0]              hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    tick_q, tick_d;
    logic                    ack_q, ack_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [4*NUM_DIGITS-1:0] shad_q, shad_d;
    logic                    pend_q, pend_d;

    logic                    wrap;
    logic [IW-1:0]           next_idx;
    logic [4*NUM_DIGITS-1:0] disp_eff;
    logic [3:0]              next_nib;
    logic                    lz_blank;
    logic                    zero_acc;
    logic [NUM_DIGITS-1:0]   onehot_n;

    // Value the next digit is drawn from: on a wrap with a pending load,
    // the shadow becomes visible on that same edge.
    always_comb begin
        wrap     = (idx_q == LAST_IDX);
        next_idx = wrap ? '0 : idx_q + 1'b1;
        disp_eff = (wrap && pend_q) ? shad_q : disp_q;
        next_nib = 4'h0;
        lz_blank = 1'b0;
        zero_acc = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_acc = zero_acc & (disp_eff[4*k +: 4] == 4'h0);
            if (IW'(k) == next_idx) begin
                next_nib = disp_eff[4*k +: 4];
                if (k != 0) lz_blank = lz_en & zero_acc;
            end
        end
        onehot_n = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << next_idx);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        hex_d   = hex_q;
        an_d    = an_q;
        tick_d  = 1'b0;
        ack_d   = 1'b0;
        disp_d  = disp_q;
        shad_d  = shad_q;
        pend_d  = pend_q;

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                    idx_d   = next_idx;
                    hex_d   = next_nib;
                    an_d    = lz_blank ? '1 : onehot_n;
                    if (wrap) begin
                        tick_d = 1'b1;
                        if (pend_q) begin
                            disp_d = shad_q;
                            pend_d = 1'b0;
                            ack_d  = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    an_d    = '1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_BLANK;
        endcase

        // A load coinciding with a wrap is captured after the old shadow is consumed.
        if (load) begin
            shad_d = value_in;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            idx_q   <= LAST_IDX;
            hex_q   <= 4'h0;
            an_q    <= '1;
            tick_q  <= 1'b0;
            ack_q   <= 1'b0;
            disp_q  <= '0;
            shad_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            hex_q   <= hex_d;
            an_q    <= an_d;
            tick_q  <= tick_d;
            ack_q   <= ack_d;
            disp_q  <= disp_d;
            shad_q  <= shad_d;
            pend_q  <= pend_d;
        end
    end

    assign hex_out    = hex_q;
    assign an_n       = an_q;
    assign digit_idx  = idx_q;
    assign frame_tick = tick_q;
    assign load_ack   = ack_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl: timeline-based reference model of the scan, loads and blanking.
`default_nettype none

module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int RD    = 4;
    localparam int BC    = 2;
    localparam int SLOT  = RD + BC;
    localparam int FRAME = ND * SLOT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value_in;
    logic        lz_en;
    logic [3:0]  hex_out;
    logic [3:0]  an_n;
    logic [1:0]  digit_idx;
    logic        frame_tick;
    logic        load_ack;

    seg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in), .lz_en(lz_en),
        .hex_out(hex_out), .an_n(an_n), .digit_idx(digit_idx),
        .frame_tick(frame_tick), .load_ack(load_ack)
    );

    always #5 clk = ~clk;

    int vectors;
    int errors;

    // Model: c counts rising edges since reset release; everything follows from
    // where c sits on the fixed BLANK/SHOW timeline.
    int          c;
    logic [15:0] m_disp, m_shad;
    bit          m_pend;
    logic [3:0]  m_hex, m_an;
    logic [1:0]  m_idx;
    bit          m_tick, m_ack;

    task automatic model_reset();
        c = 0; m_disp = 0; m_shad = 0; m_pend = 0;
        m_hex = 0; m_an = 4'hF; m_idx = 2'd3; m_tick = 0; m_ack = 0;
    endtask

    function automatic bit next_is_wrap();
        return ((c + 1) >= BC) && (((c + 1 - BC) % FRAME) == 0);
    endfunction

    task automatic cyc(input bit ld, input logic [15:0] v, input bit lz);
        int q, r, d;
        load = ld; value_in = v; lz_en = lz;
        @(posedge clk);
        c++;
        m_tick = 0; m_ack = 0;
        if (c >= BC) begin
            q = c - BC; r = q % SLOT; d = (q / SLOT) % ND;
            if (r == 0) begin
                if (d == 0) begin
                    m_tick = 1;
                    if (m_pend) begin m_disp = m_shad; m_pend = 0; m_ack = 1; end
                end
                m_idx = 2'(d);
                m_hex = m_disp[4*d +: 4];
                m_an  = (lz && d > 0 && (m_disp >> (4*d)) == 16'h0) ? 4'hF : ~(4'b0001 << d);
            end else if (r == RD) begin
                m_an = 4'hF;
            end
        end
        if (ld) begin m_shad = v; m_pend = 1; end
        #1;
        load = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; load = 0; lz_en = 0; value_in = 0;
        #12;
        if ({hex_out, an_n, digit_idx, frame_tick, load_ack} !== {4'h0, 4'hF, 2'd3, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset got hex=%h an=%b idx=%0d tick=%b ack=%b exp 0 1111 3 0 0",
                     hex_out, an_n, digit_idx, frame_tick, load_ack);
        end
        vectors++;
        model_reset();
        rst_n = 1;
    endtask

    task automatic test_scan();
        int ticks = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc(0, 16'h0, 0);
            if (frame_tick) ticks++;
            if ({hex_out, an_n, digit_idx, frame_tick, load_ack} !== {m_hex, m_an, m_idx, m_tick, m_ack}) begin
                errors++;
                $display("FAIL scan c=%0d got %h %b %0d %b %b exp %h %b %0d %b %b", c,
                         hex_out, an_n, digit_idx, frame_tick, load_ack, m_hex, m_an, m_idx, m_tick, m_ack);
            end
            vectors++;
        end
        if (ticks !== 2) begin
            errors++; $display("FAIL scan_ticks got %0d exp 2", ticks);
        end
        vectors++;
    endtask

    task automatic test_load();
        int acks = 0;
        cyc(1, 16'hA3C5, 0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc(0, 16'h0, 0);
            if (load_ack) begin
                acks++;
                if (hex_out !== 4'h5) begin
                    errors++; $display("FAIL load_first_nib got %h exp 5", hex_out);
                end
                vectors++;
            end
            if ({hex_out, an_n, digit_idx, frame_tick, load_ack} !== {m_hex, m_an, m_idx, m_tick, m_ack}) begin
                errors++;
                $display("FAIL load c=%0d got %h %b %0d %b %b exp %h %b %0d %b %b", c,
                         hex_out, an_n, digit_idx, frame_tick, load_ack, m_hex, m_an, m_idx, m_tick, m_ack);
            end
            vectors++;
        end
        if (acks !== 1) begin errors++; $display("FAIL load_acks got %0d exp 1", acks); end
        vectors++;
    endtask

    task automatic test_double_load();
        int acks = 0;
        while (!next_is_wrap()) cyc(0, 16'h0, 0);
        cyc(0, 16'h0, 0);
        cyc(1, 16'h1111, 0);
        cyc(0, 16'h0, 0);
        cyc(1, 16'h2222, 0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc(0, 16'h0, 0);
            if (load_ack) acks++;
            if (an_n != 4'hF && acks > 0 && hex_out !== 4'h2) begin
                errors++; $display("FAIL dbl_value c=%0d got %h exp 2", c, hex_out);
            end
            if ({hex_out, an_n, digit_idx, frame_tick, load_ack} !== {m_hex, m_an, m_idx, m_tick, m_ack}) begin
                errors++;
                $display("FAIL dbl c=%0d got %h %b %0d %b %b exp %h %b %0d %b %b", c,
                         hex_out, an_n, digit_idx, frame_tick, load_ack, m_hex, m_an, m_idx, m_tick, m_ack);
            end
            vectors++;
        end
        if (acks !== 1) begin errors++; $display("FAIL dbl_acks got %0d exp 1", acks); end
        vectors++;
    endtask

    task automatic test_load_on_wrap();
        while (next_is_wrap()) cyc(0, 16'h0, 0);
        cyc(1, 16'h1234, 0);
        while (!next_is_wrap()) cyc(0, 16'h0, 0);
        cyc(1, 16'h5678, 0);
        if ({load_ack, hex_out} !== {1'b1, 4'h4}) begin
            errors++; $display("FAIL wrap_load1 got ack=%b hex=%h exp ack=1 hex=4", load_ack, hex_out);
        end
        vectors++;
        for (int i = 0; i < FRAME; i++) begin
            cyc(0, 16'h0, 0);
            if ({hex_out, an_n, digit_idx, frame_tick, load_ack} !== {m_hex, m_an, m_idx, m_tick, m_ack}) begin
                errors++;
                $display("FAIL wrapld c=%0d got %h %b %0d %b %b exp %h %b %0d %b %b", c,
                         hex_out, an_n, digit_idx, frame_tick, load_ack, m_hex, m_an, m_idx, m_tick, m_ack);
            end
            vectors++;
        end
        if ({load_ack, hex_out} !== {1'b1, 4'h8}) begin
            errors++; $display("FAIL wrap_load2 got ack=%b hex=%h exp ack=1 hex=8", load_ack, hex_out);
        end
        vectors++;
    endtask

    task automatic test_lz(input logic [15:0] v, input logic [3:0] allowed_off);
        bit applied = 0;
        cyc(1, v, 1);
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc(0, 16'h0, 1);
            if (load_ack) applied = 1;
            if (applied && an_n != 4'hF && (~an_n & ~allowed_off) != 4'h0) begin
                errors++; $display("FAIL lz_dark v=%h got an=%b", v, an_n);
            end
            if ({hex_out, an_n, digit_idx, frame_tick, load_ack} !== {m_hex, m_an, m_idx, m_tick, m_ack}) begin
                errors++;
                $display("FAIL lz c=%0d got %h %b %0d %b %b exp %h %b %0d %b %b", c,
                         hex_out, an_n, digit_idx, frame_tick, load_ack, m_hex, m_an, m_idx, m_tick, m_ack);
            end
            vectors++;
        end
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        int guard = 0;
        while (!m_tick && guard < 2 * FRAME) begin cyc(0, 16'h0, 0); guard++; end
        cyc(1, 16'h9876, 0);
        guard = 0;
        while (!(m_idx == 2'd2 && m_an != 4'hF) && guard < 2 * FRAME) begin cyc(0, 16'h0, 0); guard++; end
        cyc(0, 16'h0, 0);
        if (an_n === 4'hF) begin errors++; $display("FAIL rst_mid_setup got an=%b exp digit 2 lit", an_n); end
        vectors++;
        #2 rst_n = 0;
        #1;
        if ({an_n, hex_out, digit_idx} !== {4'hF, 4'h0, 2'd3}) begin
            errors++; $display("FAIL rst_async got an=%b hex=%h idx=%0d exp 1111 0 3", an_n, hex_out, digit_idx);
        end
        vectors++;
        @(posedge clk); #1;
        model_reset();
        rst_n = 1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc(0, 16'h0, 0);
            if (load_ack) acks++;
            if ({hex_out, an_n, digit_idx, frame_tick, load_ack} !== {m_hex, m_an, m_idx, m_tick, m_ack}) begin
                errors++;
                $display("FAIL rstmid c=%0d got %h %b %0d %b %b exp %h %b %0d %b %b", c,
                         hex_out, an_n, digit_idx, frame_tick, load_ack, m_hex, m_an, m_idx, m_tick, m_ack);
            end
            vectors++;
        end
        if (acks !== 0) begin errors++; $display("FAIL rst_no_ack got %0d exp 0", acks); end
        vectors++;
    endtask

    task automatic test_random();
        logic [15:0] v;
        for (int i = 0; i < 600; i++) begin
            v = 16'($urandom);
            if ($urandom_range(0, 1) == 1) v = v & 16'h00FF;
            cyc(($urandom_range(0, 19) == 0), v, 1'($urandom_range(0, 1)));
            if ($countones(~an_n) > 1) begin
                errors++; $display("FAIL rand_onehot c=%0d got an=%b", c, an_n);
            end
            if ({hex_out, an_n, digit_idx, frame_tick, load_ack} !== {m_hex, m_an, m_idx, m_tick, m_ack}) begin
                errors++;
                $display("FAIL rand c=%0d got %h %b %0d %b %b exp %h %b %0d %b %b", c,
                         hex_out, an_n, digit_idx, frame_tick, load_ack, m_hex, m_an, m_idx, m_tick, m_ack);
            end
            vectors++;
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_scan();
        test_load();
        test_double_load();
        test_load_on_wrap();
        test_lz(16'h0040, 4'b0011);
        test_lz(16'h0000, 4'b0001);
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
